// File: rtl/bus_initiator_if.sv
// Command/response handshakes plus the Uniboard select/rw/address/size bus lines.
// The tri-state databus stays a plain inout on the initiator.
interface bus_initiator_if #(
    parameter int NUM_PERIPH = 4,
    parameter int PERIPH_W   = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [PERIPH_W-1:0]   cmd_periph;
    logic                  cmd_rw;
    logic [7:0]            cmd_addr;
    logic [31:0]           cmd_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [31:0]           rsp_data;
    logic [2:0]            rsp_size;
    logic                  rsp_err;

    logic [NUM_PERIPH-1:0] select;
    logic                  rw;
    logic [7:0]            register_addr;
    logic [2:0]            reg_size;

    modport master (
        input  cmd_valid, cmd_periph, cmd_rw, cmd_addr, cmd_wdata, rsp_ready, reg_size,
        output cmd_ready, rsp_valid, rsp_data, rsp_size, rsp_err, select, rw, register_addr
    );

    modport slave (
        output cmd_valid, cmd_periph, cmd_rw, cmd_addr, cmd_wdata, rsp_ready, reg_size,
        input  cmd_ready, rsp_valid, rsp_data, rsp_size, rsp_err, select, rw, register_addr
    );
endinterface

// File: rtl/bus_initiator.sv
// Uniboard peripheral bus initiator: one register command at a time, sequenced as
// setup -> select strobe -> recover, then a held response until the consumer takes it.
module bus_initiator #(
    parameter int NUM_PERIPH    = 4,
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 4,
    parameter int PERIPH_W      = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1
) (
    input  logic            clk_12MHz,
    input  logic            reset,
    bus_initiator_if.master bus,
    inout  wire [31:0]      databus
);
    localparam int MAX_CYCLES = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam int LIMIT_W    = PERIPH_W + 1;

    localparam logic [CW-1:0]     SETUP_LOAD   = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0]     STROBE_LOAD  = CW'(STROBE_CYCLES - 1);
    localparam logic [PERIPH_W:0] PERIPH_LIMIT = LIMIT_W'(NUM_PERIPH);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        RECOVER,
        RESP
    } state_t;

    state_t                state_reg, state_next;
    logic [CW-1:0]         cnt_reg, cnt_next;
    logic [PERIPH_W-1:0]   periph_reg, periph_next;
    logic                  rw_reg, rw_next;
    logic [7:0]            addr_reg, addr_next;
    logic [31:0]           wdata_reg, wdata_next;
    logic                  drive_reg, drive_next;
    logic [NUM_PERIPH-1:0] select_reg, select_next;
    logic [31:0]           rsp_data_reg, rsp_data_next;
    logic [2:0]            rsp_size_reg, rsp_size_next;
    logic                  rsp_err_reg, rsp_err_next;
    logic [NUM_PERIPH-1:0] periph_onehot;

    for (genvar gi = 0; gi < NUM_PERIPH; gi++) begin : g_decode
        assign periph_onehot[gi] = (periph_reg == PERIPH_W'(gi));
    end

    always_ff @(posedge clk_12MHz or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            periph_reg   <= '0;
            rw_reg       <= 1'b1;
            addr_reg     <= '0;
            wdata_reg    <= '0;
            drive_reg    <= 1'b0;
            select_reg   <= '0;
            rsp_data_reg <= '0;
            rsp_size_reg <= '0;
            rsp_err_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            periph_reg   <= periph_next;
            rw_reg       <= rw_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
            drive_reg    <= drive_next;
            select_reg   <= select_next;
            rsp_data_reg <= rsp_data_next;
            rsp_size_reg <= rsp_size_next;
            rsp_err_reg  <= rsp_err_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        periph_next   = periph_reg;
        rw_next       = rw_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;
        drive_next    = drive_reg;
        select_next   = select_reg;
        rsp_data_next = rsp_data_reg;
        rsp_size_next = rsp_size_reg;
        rsp_err_next  = rsp_err_reg;

        case (state_reg)
            IDLE: begin
                if (bus.cmd_valid) begin
                    periph_next = bus.cmd_periph;
                    rw_next     = bus.cmd_rw;
                    addr_next   = bus.cmd_addr;
                    wdata_next  = bus.cmd_wdata;
                    // Out-of-range targets never touch the bus; answer straight away.
                    if ({1'b0, bus.cmd_periph} >= PERIPH_LIMIT) begin
                        rsp_err_next  = 1'b1;
                        rsp_data_next = '0;
                        rsp_size_next = '0;
                        state_next    = RESP;
                    end else begin
                        cnt_next   = SETUP_LOAD;
                        drive_next = ~bus.cmd_rw;
                        state_next = SETUP;
                    end
                end
            end
            SETUP: begin
                if (cnt_reg == '0) begin
                    cnt_next    = STROBE_LOAD;
                    select_next = periph_onehot;
                    state_next  = STROBE;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            STROBE: begin
                if (cnt_reg == '0) begin
                    // Last select-high cycle: the peripheral has had the whole strobe to respond.
                    select_next   = '0;
                    rsp_size_next = bus.reg_size;
                    rsp_err_next  = (bus.reg_size == 3'd0);
                    rsp_data_next = (rw_reg && bus.reg_size != 3'd0) ? databus : '0;
                    state_next    = RECOVER;
                end else begin
                    cnt_next = cnt_reg - CW'(1);
                end
            end
            RECOVER: begin
                drive_next = 1'b0;
                state_next = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.cmd_ready     = (state_reg == IDLE);
    assign bus.rsp_valid     = (state_reg == RESP);
    assign bus.rsp_data      = rsp_data_reg;
    assign bus.rsp_size      = rsp_size_reg;
    assign bus.rsp_err       = rsp_err_reg;
    assign bus.select        = select_reg;
    assign bus.rw            = rw_reg;
    assign bus.register_addr = addr_reg;

    assign databus = drive_reg ? wdata_reg : {32{1'bz}};
endmodule

// File: tb/tb_bus_initiator.sv
// Bench for bus_initiator: a register-file responder on the bus, a shadow register model
// predicting every response, and cycle-by-cycle checks of the bus waveform.
module tb_bus_initiator;
    localparam int NP  = 4;
    localparam int PW  = 3;   // wide enough to express out-of-range indices
    localparam int SU  = 2;
    localparam int ST  = 4;
    localparam int LAT = SU + ST + 1;
    localparam logic [31:0] PULLED = 32'hFFFF_FFFF;

    logic clk_12MHz = 1'b0;
    logic reset     = 1'b1;
    wire  [31:0] databus;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_12MHz = ~clk_12MHz;

    pullup (databus);

    bus_initiator_if #(.NUM_PERIPH(NP), .PERIPH_W(PW)) bif ();

    bus_initiator #(
        .NUM_PERIPH(NP),
        .SETUP_CYCLES(SU),
        .STROBE_CYCLES(ST),
        .PERIPH_W(PW)
    ) dut (
        .clk_12MHz(clk_12MHz),
        .reset(reset),
        .bus(bif),
        .databus(databus)
    );

    // Peripheral register map: addresses F0..FF are unmapped.
    function automatic logic [2:0] size_of(input logic [7:0] a);
        if (a >= 8'hF0) return 3'd0;
        return 3'd1 + {1'b0, a[7:6]};
    endfunction

    function automatic logic [31:0] reset_val(input int p, input logic [7:0] a);
        if (p == 1 && a == 8'h00) return 32'h0000_007F;
        return {8'hC0, 8'(p), 8'h5E, a};
    endfunction

    // ---------------- responder (bus fixture) ----------------
    logic [31:0] mem [NP][256];
    logic        written [NP][256] = '{default: '{default: 1'b0}};
    logic        sel_seen = 1'b0;
    int          sel_idx;
    logic [31:0] rd_word;

    always_comb begin
        sel_idx = 0;
        for (int i = 0; i < NP; i++) if (bif.select[i]) sel_idx = i;
    end

    always_comb begin
        rd_word = written[sel_idx][bif.register_addr] ? mem[sel_idx][bif.register_addr]
                                                      : reset_val(sel_idx, bif.register_addr);
    end

    assign bif.reg_size = (|bif.select) ? size_of(bif.register_addr) : 3'd0;
    assign databus      = ((|bif.select) && bif.rw) ? rd_word : {32{1'bz}};

    always @(negedge clk_12MHz) begin
        if ((|bif.select) && !sel_seen && !bif.rw && size_of(bif.register_addr) != 3'd0) begin
            mem[sel_idx][bif.register_addr]     <= databus;
            written[sel_idx][bif.register_addr] <= 1'b1;
        end
        sel_seen <= |bif.select;
    end

    // ---------------- reference model ----------------
    logic [31:0] shadow    [NP][256];
    logic        shadow_ok [NP][256] = '{default: '{default: 1'b0}};

    logic        c_rw;
    int          c_p;
    logic [7:0]  c_a;
    logic [31:0] c_wd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input int p, input logic rw, input logic [7:0] a, input logic [31:0] wd,
                           input int hold, input logic chain, input logic expect_now);
        logic          bad;
        logic [2:0]    sz;
        logic [31:0]   word;
        logic [31:0]   exp_data;
        logic [31:0]   exp_bus;
        logic [NP-1:0] one;
        logic [NP-1:0] exp_sel;
        logic          in_strobe;
        int            lat;
        int            waited;

        one      = 1;
        bad      = (p >= NP);
        sz       = bad ? 3'd0 : size_of(a);
        word     = 32'h0;
        if (!bad) word = shadow_ok[p][a] ? shadow[p][a] : reset_val(p, a);
        exp_data = (!bad && rw && sz != 3'd0) ? word : 32'h0;
        lat      = bad ? 0 : LAT;

        waited = 0;
        while (!bif.cmd_ready && waited < 50) begin
            @(negedge clk_12MHz);
            waited++;
        end
        check("cmd_ready_idle", 32'(bif.cmd_ready), 32'd1);
        if (expect_now) check("accept_next_cycle", 32'(waited), 32'd0);

        bif.cmd_valid  = 1'b1;
        bif.cmd_periph = PW'(p);
        bif.cmd_rw     = rw;
        bif.cmd_addr   = a;
        bif.cmd_wdata  = wd;
        @(posedge clk_12MHz);
        @(negedge clk_12MHz);
        if (chain) begin
            bif.cmd_periph = PW'(c_p);
            bif.cmd_rw     = c_rw;
            bif.cmd_addr   = c_a;
            bif.cmd_wdata  = c_wd;
        end else begin
            bif.cmd_valid = 1'b0;
        end
        if (!bad && !rw && sz != 3'd0) begin
            shadow[p][a]    = wd;
            shadow_ok[p][a] = 1'b1;
        end

        // k counts clock edges since the accept edge
        for (int k = 0; k <= lat; k++) begin
            in_strobe = !bad && k >= SU && k < SU + ST;
            exp_sel   = in_strobe ? (one << p) : '0;
            if (!bad && !rw && k <= SU + ST) exp_bus = wd;
            else if (in_strobe && rw)        exp_bus = word;
            else                             exp_bus = PULLED;
            check("select", 32'(bif.select), 32'(exp_sel));
            check("databus", databus, exp_bus);
            check("rsp_valid_timing", 32'(bif.rsp_valid), 32'(k == lat));
            check("cmd_ready_busy", 32'(bif.cmd_ready), 32'd0);
            check("rw_stable", 32'(bif.rw), 32'(rw));
            check("addr_stable", 32'(bif.register_addr), 32'(a));
            if (k < lat) @(negedge clk_12MHz);
        end

        for (int h = 0; h <= hold; h++) begin
            check("rsp_valid_held", 32'(bif.rsp_valid), 32'd1);
            check("rsp_data", bif.rsp_data, exp_data);
            check("rsp_size", 32'(bif.rsp_size), 32'(sz));
            check("rsp_err", 32'(bif.rsp_err), 32'(bad || sz == 3'd0));
            check("cmd_ready_resp", 32'(bif.cmd_ready), 32'd0);
            if (h == hold) bif.rsp_ready = 1'b1;
            @(negedge clk_12MHz);
        end
        bif.rsp_ready = 1'b0;
        check("rsp_valid_drop", 32'(bif.rsp_valid), 32'd0);
        check("cmd_ready_back", 32'(bif.cmd_ready), 32'd1);
        $display("txn periph=%0d rw=%0d addr=%02h wdata=%08h -> data=%08h size=%0d err=%0d hold=%0d",
                 p, rw, a, wd, exp_data, sz, (bad || sz == 3'd0), hold);
    endtask

    initial begin
        logic [7:0]  ra;
        logic [31:0] rwd;

        bif.cmd_valid  = 1'b0;
        bif.cmd_periph = '0;
        bif.cmd_rw     = 1'b0;
        bif.cmd_addr   = '0;
        bif.cmd_wdata  = '0;
        bif.rsp_ready  = 1'b0;
        c_p = 0; c_rw = 1'b0; c_a = 8'h0; c_wd = 32'h0;

        #1 reset = 1'b0;
        #1;
        check("reset_select", 32'(bif.select), 32'd0);
        check("reset_rw", 32'(bif.rw), 32'd1);
        check("reset_addr", 32'(bif.register_addr), 32'd0);
        check("reset_cmd_ready", 32'(bif.cmd_ready), 32'd1);
        check("reset_rsp_valid", 32'(bif.rsp_valid), 32'd0);
        check("reset_rsp_data", bif.rsp_data, 32'd0);
        check("reset_rsp_size", 32'(bif.rsp_size), 32'd0);
        check("reset_rsp_err", 32'(bif.rsp_err), 32'd0);
        check("reset_databus", databus, PULLED);
        repeat (2) @(negedge clk_12MHz);
        reset = 1'b1;
        @(negedge clk_12MHz);

        run_cmd(0, 1'b0, 8'h01, 32'h0000_005A, 0, 1'b0, 1'b0);   // write
        run_cmd(1, 1'b1, 8'h00, 32'h0,         0, 1'b0, 1'b0);   // read 0x7F
        run_cmd(3, 1'b1, 8'hF5, 32'h0,         0, 1'b0, 1'b0);   // unmapped read
        run_cmd(5, 1'b1, 8'h10, 32'h0,         0, 1'b0, 1'b0);   // index out of range
        run_cmd(0, 1'b1, 8'h01, 32'h0,         0, 1'b0, 1'b0);   // read back the write

        // Response stalled 10 clocks while the next command waits on cmd_valid.
        c_p = 2; c_rw = 1'b0; c_a = 8'h42; c_wd = 32'hDEAD_BEEF;
        run_cmd(3, 1'b1, 8'h10, 32'h0, 10, 1'b1, 1'b0);
        run_cmd(c_p, c_rw, c_a, c_wd, 0, 1'b0, 1'b1);
        run_cmd(2, 1'b1, 8'h42, 32'h0, 0, 1'b0, 1'b0);

        // Reset in the middle of a strobe.
        bif.cmd_valid  = 1'b1;
        bif.cmd_periph = PW'(2);
        bif.cmd_rw     = 1'b1;
        bif.cmd_addr   = 8'h03;
        @(posedge clk_12MHz);
        @(negedge clk_12MHz);
        bif.cmd_valid = 1'b0;
        repeat (3) @(negedge clk_12MHz);
        check("abort_in_strobe", 32'(bif.select), 32'h4);
        #2 reset = 1'b0;
        #1;
        check("abort_select", 32'(bif.select), 32'd0);
        check("abort_databus", databus, PULLED);
        check("abort_cmd_ready", 32'(bif.cmd_ready), 32'd1);
        check("abort_rsp_valid", 32'(bif.rsp_valid), 32'd0);
        @(negedge clk_12MHz);
        reset = 1'b1;
        @(negedge clk_12MHz);
        check("post_abort_rsp_valid", 32'(bif.rsp_valid), 32'd0);
        run_cmd(2, 1'b1, 8'h03, 32'h0, 0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            ra  = ($urandom_range(0, 5) == 0) ? (8'hF0 | 8'($urandom_range(0, 15)))
                                              : {2'($urandom_range(0, 3)), 4'h0, 2'($urandom_range(0, 3))};
            rwd = $urandom;
            run_cmd($urandom_range(0, 4), 1'($urandom_range(0, 1)), ra, rwd,
                    $urandom_range(0, 3), 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
